stencil_dsp: RTL
================

# stencil_dsp

Parametrised, streaming 3×3 pixel-stencil engine that replaces the fixed single-mode pixel DSP fed from r16–r18. It accepts one packed column beat per cycle over a valid/ready handshake: top, middle and bottom row words, each holding LANES pixels. It applies a per-beat selectable kernel across all lanes in parallel, with horizontal edge replication at line boundaries. It returns one packed, saturated result word per input word through a 3-stage stallable pipeline.

## Interface
- PIX_W, default 8: bits per pixel (unsigned).
- LANES, default 4: pixels per word; DATA_W = PIX_W*LANES. Lane 0 is bits [PIX_W-1:0] and is the leftmost pixel.
- clk  input  1  clock. All state is on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  input beat offered.
- in_ready  output  1  input beat accepted this cycle when in_valid && in_ready.
- in_top, in_mid, in_bot  input  DATA_W each  column words for rows y-1, y and y+1.
- in_mode  input  2  kernel for this beat (dsp_mode_t), captured with the beat.
- in_sol  input  1  beat is the first word of a line.
- in_eol  input  1  beat is the last word of a line. in_sol and in_eol may both be set.
- out_valid  output  1  result word held.
- out_ready  input  1  downstream accepts when out_valid && out_ready.
- out_data  output  DATA_W  packed result pixels.
- out_eol  output  1  result belongs to the last word of a line.
- busy  output  1  any pipeline stage valid or a drain is pending.

## Operation
- Window: three column registers (left, centre, right word, 3 rows each), shifted on every accepted beat. The centre word is computed once its right neighbour is known.
- Neighbour of lane i:
  - Left neighbour: lane i-1 of the same word; for lane 0, lane LANES-1 of the left word.
  - Right neighbour: lane i+1 of the same word; for lane LANES-1, lane 0 of the right word.
- Edge replication:
  - On an in_sol beat, the left neighbour of lane 0 is lane 0 itself.
  - For the eol word, the right neighbour of lane LANES-1 is itself.
  - Vertical neighbours are always the supplied rows.
- Output schedule per line:
  - The sol beat produces no result.
  - Each later beat produces the result for the previous word.
  - After an eol beat, a drain cycle produces the eol word's result with out_eol=1.
  - A line of N words gives exactly N results.
- Drain: on acceptance of an eol beat, in_ready drops for exactly one enabled cycle while the drain result enters the pipeline.
- Modes, with c = centre; n, s, e, w = edge neighbours; corners = diagonals. All arithmetic is signed PIX_W+5 bits, and results clamp to [0, 2^PIX_W-1].
  - DSP_PASS (0): c.
  - DSP_GAUSS (1): (4c + 2(n+s+e+w) + corners) >> 4, truncating.
  - DSP_SHARP (2): 5c − n − s − e − w, clamped.
  - DSP_SOBEL (3): |Gx| + |Gy|, clamped.
    - Gx = (ne + 2e + se) − (nw + 2w + sw).
    - Gy = (sw + 2s + se) − (nw + 2n + ne).
- The mode is that of the centre word's beat, so a mode change takes effect on a word boundary.

## Timing
- Reset (async assert, sync deassert handled upstream) clears:
  - all stage valids, the drain flag and window sol/eol flags;
  - outputs: out_valid=0, out_data=0, out_eol=0, busy=0.
  - in_ready=1 immediately after reset.
- Stages:
  - S0: window registers.
  - S1: per-lane raw sums, registered.
  - S2: clamped output register.
- Global enable en = !out_valid || out_ready. All stages hold when en=0.
- in_ready = en && !drain_pending.
- Latency: a result is visible on out_valid 2 cycles after the edge that accepted its right-neighbour beat (or the drain edge).
- Throughput: 1 word/cycle sustained. Lines of N words take N+1 input-side cycles.
- out_data and out_eol are stable while out_valid && !out_ready.
- Simultaneous in_sol and in_eol: replicate both edges; result is produced via drain; busy stays asserted through drain.
- Back-to-back lines: an in_sol beat may be accepted in the cycle after the drain.
- Reset mid-line or mid-stall discards all in-flight results; no partial output follows.

## Structure
- Shared package dsp_pkg holds:
  - typedef dsp_mode_t {DSP_PASS, DSP_GAUSS, DSP_SHARP, DSP_SOBEL};
  - localparam kernel weights;
  - an accumulator-width function ACC_W(PIX_W) = PIX_W+5.
- One sub-module, stencil_lane: combinational 3×3 kernel for one pixel, producing the raw signed sum. It is instantiated LANES times (generate) and feeds the S1 register. Clamping stays in the top level at S2.

## Test plan
- PASS mode:
  - Stimulus: PIX_W=8, LANES=4; 3-word line (sol on word 0, eol on word 2), mid words 0x04030201, 0x08070605, 0x0C0B0A09; out_ready=1.
  - Response: 3 results equal to the mid words, out_eol only on the third; in_ready low for one cycle after eol.
- GAUSS mode:
  - Stimulus: flat field with all pixels 0x80.
  - Response: every lane 0x80, including edge lanes (replication check).
- SHARP saturation:
  - Stimulus: centre 0xFF, neighbours 0x00.
  - Response: 0xFF.
  - Stimulus: centre 0x00, neighbours 0xFF.
  - Response: 0x00.
- SOBEL:
  - Stimulus: vertical edge, left columns 0x00, right columns 0xFF, across a word boundary.
  - Response: lanes beside the edge 0xFF (clamped 1020), flat lanes 0x00.
- Backpressure:
  - Stimulus: out_ready toggled 1-0-0-1 during a 4-word line.
  - Response: no result lost or duplicated; out_data held while stalled; order preserved.
- Boundaries:
  - Stimulus: single-word line (sol and eol both set).
  - Response: one result with out_eol=1.
  - Stimulus: rst_n pulsed low while busy.
  - Response: out_valid=0 and busy=0 at once; the next line produces correct results.

Source files
------------

// File: rtl/dsp_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// dsp_pkg : shared kernel modes, weights and accumulator sizing
// Rev 1.0
// ------------------------------------------------------------------
package dsp_pkg;

  typedef enum logic [1:0] {
    DSP_PASS  = 2'd0,
    DSP_GAUSS = 2'd1,
    DSP_SHARP = 2'd2,
    DSP_SOBEL = 2'd3
  } dsp_mode_t;

  localparam int GAUSS_W_C      = 4;
  localparam int GAUSS_W_EDGE   = 2;
  localparam int GAUSS_W_CORNER = 1;
  localparam int GAUSS_SHIFT    = 4;
  localparam int SHARP_W_C      = 5;
  localparam int SOBEL_W_SIDE   = 2;
  localparam int ACC_GUARD      = 5;

  function automatic int ACC_W(input int pix_w);
    return pix_w + ACC_GUARD;
  endfunction

endpackage
`default_nettype wire

// File: rtl/stencil_lane.sv
`default_nettype none
// ------------------------------------------------------------------
// stencil_lane : combinational 3x3 kernel for one pixel, raw signed sum
// Rev 1.0
// ------------------------------------------------------------------
module stencil_lane
  import dsp_pkg::*;
#(
  parameter  int PIX_W = 8,
  localparam int AW    = ACC_W(PIX_W)
) (
  input  dsp_mode_t              mode,
  input  logic [PIX_W-1:0]       nw,
  input  logic [PIX_W-1:0]       n,
  input  logic [PIX_W-1:0]       ne,
  input  logic [PIX_W-1:0]       w,
  input  logic [PIX_W-1:0]       c,
  input  logic [PIX_W-1:0]       e,
  input  logic [PIX_W-1:0]       sw,
  input  logic [PIX_W-1:0]       s,
  input  logic [PIX_W-1:0]       se,
  output logic signed [AW-1:0]   sum
);

  localparam logic signed [AW-1:0] K_GC = AW'(GAUSS_W_C);
  localparam logic signed [AW-1:0] K_GE = AW'(GAUSS_W_EDGE);
  localparam logic signed [AW-1:0] K_GK = AW'(GAUSS_W_CORNER);
  localparam logic signed [AW-1:0] K_SC = AW'(SHARP_W_C);
  localparam logic signed [AW-1:0] K_SS = AW'(SOBEL_W_SIDE);

  function automatic logic signed [AW-1:0] ext(input logic [PIX_W-1:0] p);
    return signed'({{(AW-PIX_W){1'b0}}, p});
  endfunction

  logic signed [AW-1:0] xnw, xn, xne, xw, xc, xe, xsw, xs, xse;
  logic signed [AW-1:0] gauss_acc, sharp, gx, gy, abs_gx, abs_gy;

  assign xnw = ext(nw);
  assign xn  = ext(n);
  assign xne = ext(ne);
  assign xw  = ext(w);
  assign xc  = ext(c);
  assign xe  = ext(e);
  assign xsw = ext(sw);
  assign xs  = ext(s);
  assign xse = ext(se);

  assign gauss_acc = K_GC * xc + K_GE * (xn + xs + xe + xw)
                   + K_GK * (xnw + xne + xsw + xse);
  assign sharp     = K_SC * xc - xn - xs - xe - xw;
  assign gx        = (xne + K_SS * xe + xse) - (xnw + K_SS * xw + xsw);
  assign gy        = (xsw + K_SS * xs + xse) - (xnw + K_SS * xn + xne);
  assign abs_gx    = gx[AW-1] ? -gx : gx;
  assign abs_gy    = gy[AW-1] ? -gy : gy;

  always_comb begin
    sum = xc;
    case (mode)
      DSP_PASS:  sum = xc;
      DSP_GAUSS: sum = gauss_acc >>> GAUSS_SHIFT;
      DSP_SHARP: sum = sharp;
      DSP_SOBEL: sum = abs_gx + abs_gy;
      default:   sum = xc;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/stencil_dsp.sv
`default_nettype none
// ------------------------------------------------------------------
// stencil_dsp : streaming 3x3 stencil engine, LANES pixels per beat
// Rev 1.0
// ------------------------------------------------------------------
module stencil_dsp
  import dsp_pkg::*;
#(
  parameter  int PIX_W  = 8,
  parameter  int LANES  = 4,
  localparam int DATA_W = PIX_W * LANES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_top,
  input  logic [DATA_W-1:0] in_mid,
  input  logic [DATA_W-1:0] in_bot,
  input  logic [1:0]        in_mode,
  input  logic              in_sol,
  input  logic              in_eol,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_eol,
  output logic              busy
);

  localparam int AW = ACC_W(PIX_W);

  logic en, accept, shift, drain_pending;

  // Left column only ever contributes its rightmost lane.
  logic [PIX_W-1:0]  left_px [3];
  logic [DATA_W-1:0] win_c   [3];
  logic [DATA_W-1:0] win_r   [3];
  logic              c_sol, c_eol, r_sol, r_eol;
  dsp_mode_t         c_mode, r_mode;

  logic              s0_valid, s1_valid, s1_eol;
  logic signed [AW-1:0] lane_sum [LANES];
  logic signed [AW-1:0] s1_sum   [LANES];
  logic [DATA_W-1:0] clamp_word;

  assign en       = !out_valid || out_ready;
  assign in_ready = en && !drain_pending;
  assign accept   = in_valid && in_ready;
  assign shift    = accept || (en && drain_pending);
  assign busy     = s0_valid || s1_valid || out_valid || drain_pending;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < 3; r++) begin
        left_px[r] <= '0;
        win_c[r]   <= '0;
        win_r[r]   <= '0;
      end
      c_sol         <= 1'b0;
      c_eol         <= 1'b0;
      r_sol         <= 1'b0;
      r_eol         <= 1'b0;
      c_mode        <= DSP_PASS;
      r_mode        <= DSP_PASS;
      s0_valid      <= 1'b0;
      drain_pending <= 1'b0;
    end else begin
      if (shift) begin
        for (int r = 0; r < 3; r++) begin
          left_px[r] <= win_c[r][(LANES-1)*PIX_W +: PIX_W];
          win_c[r]   <= win_r[r];
        end
        c_sol  <= r_sol;
        c_eol  <= r_eol;
        c_mode <= r_mode;
      end
      if (accept) begin
        win_r[0] <= in_top;
        win_r[1] <= in_mid;
        win_r[2] <= in_bot;
        r_sol    <= in_sol;
        r_eol    <= in_eol;
        r_mode   <= dsp_mode_t'(in_mode);
      end
      if (en) begin
        s0_valid <= (accept && !in_sol) || drain_pending;
      end
      // A drain cycle re-centres the eol word without consuming a beat.
      if (accept && in_eol) begin
        drain_pending <= 1'b1;
      end else if (en) begin
        drain_pending <= 1'b0;
      end
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [PIX_W-1:0] pw [3];
    logic [PIX_W-1:0] pc [3];
    logic [PIX_W-1:0] pe [3];

    for (genvar r = 0; r < 3; r++) begin : g_row
      assign pc[r] = win_c[r][i*PIX_W +: PIX_W];
      if (i == 0) begin : g_w_edge
        assign pw[r] = c_sol ? win_c[r][PIX_W-1:0] : left_px[r];
      end else begin : g_w_inner
        assign pw[r] = win_c[r][(i-1)*PIX_W +: PIX_W];
      end
      if (i == LANES - 1) begin : g_e_edge
        assign pe[r] = c_eol ? win_c[r][(LANES-1)*PIX_W +: PIX_W] : win_r[r][PIX_W-1:0];
      end else begin : g_e_inner
        assign pe[r] = win_c[r][(i+1)*PIX_W +: PIX_W];
      end
    end

    stencil_lane #(.PIX_W(PIX_W)) u_lane (
      .mode (c_mode),
      .nw   (pw[0]), .n (pc[0]), .ne (pe[0]),
      .w    (pw[1]), .c (pc[1]), .e  (pe[1]),
      .sw   (pw[2]), .s (pc[2]), .se (pe[2]),
      .sum  (lane_sum[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_eol   <= 1'b0;
      for (int i = 0; i < LANES; i++) s1_sum[i] <= '0;
    end else if (en) begin
      s1_valid <= s0_valid;
      s1_eol   <= c_eol;
      for (int i = 0; i < LANES; i++) s1_sum[i] <= lane_sum[i];
    end
  end

  always_comb begin
    clamp_word = '0;
    for (int i = 0; i < LANES; i++) begin
      if (s1_sum[i][AW-1]) begin
        clamp_word[i*PIX_W +: PIX_W] = '0;
      end else if (|s1_sum[i][AW-2:PIX_W]) begin
        clamp_word[i*PIX_W +: PIX_W] = '1;
      end else begin
        clamp_word[i*PIX_W +: PIX_W] = s1_sum[i][PIX_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_eol   <= 1'b0;
    end else if (en) begin
      out_valid <= s1_valid;
      out_data  <= clamp_word;
      out_eol   <= s1_valid && s1_eol;
    end
  end

endmodule
`default_nettype wire
